// File: rtl/button_debouncer_if.sv
// Button conditioner bus.
//   btn_in        raw, bouncing push-button level (asynchronous to clk)
//   btn_level     debounced level
//   press_pulse   one-cycle strobe on an accepted press
//   release_pulse one-cycle strobe on an accepted release
//   long_pulse    one-cycle strobe when a press is held past the long threshold
//   toggle        inverts on every accepted press
//   press_count   accepted presses, modulo 256
// The slave modport is the debouncer; the master modport is whoever owns the
// button and consumes the conditioned outputs.
interface button_debouncer_if;
    logic       btn_in;
    logic       btn_level;
    logic       press_pulse;
    logic       release_pulse;
    logic       long_pulse;
    logic       toggle;
    logic [7:0] press_count;

    modport slave (
        input  btn_in,
        output btn_level, press_pulse, release_pulse, long_pulse, toggle, press_count
    );

    modport master (
        output btn_in,
        input  btn_level, press_pulse, release_pulse, long_pulse, toggle, press_count
    );
endinterface

// File: rtl/button_debouncer.sv
// Single push-button conditioner.
// The raw button is brought into the clk domain by a two-flop synchroniser.
// A four-state FSM then debounces it. The block produces a clean level,
// press/release/long-press strobes, a toggle bit and an 8-bit press counter.
// Ports:
//   clk   system clock, rising edge
//   rst_n asynchronous active-low reset; clears every flop
//   bus   button_debouncer_if.slave (btn_in in, conditioned outputs out)
// Parameters:
//   DEBOUNCE_CYCLES  stable cycles needed to accept a level change (>= 2)
//   LONG_CYCLES      cycles held in PRESSED before long_pulse (>= 1)
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int LONG_CYCLES     = 100_000_000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    button_debouncer_if.slave     bus
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam int LW = $clog2(LONG_CYCLES + 1);
    localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [LW-1:0] L_LAST = LW'(LONG_CYCLES - 1);

    localparam logic [1:0] S_IDLE       = 2'd0;
    localparam logic [1:0] S_DB_PRESS   = 2'd1;
    localparam logic [1:0] S_PRESSED    = 2'd2;
    localparam logic [1:0] S_DB_RELEASE = 2'd3;

    logic          sync1_q, btn_s_q;
    logic [1:0]    state_q, state_d;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic [LW-1:0] lcnt_q, lcnt_d;
    logic          long_done_q, long_done_d;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic          rel_q, rel_d;
    logic          long_q, long_d;
    logic          toggle_q, toggle_d;
    logic [7:0]    count_q, count_d;

    always_comb begin
        state_d     = state_q;
        dcnt_d      = dcnt_q;
        lcnt_d      = lcnt_q;
        long_done_d = long_done_q;
        level_d     = level_q;
        toggle_d    = toggle_q;
        count_d     = count_q;
        // Strobes are high for one cycle only.
        press_d     = 1'b0;
        rel_d       = 1'b0;
        long_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (btn_s_q) begin
                    state_d = S_DB_PRESS;
                    dcnt_d  = '0;
                end
            end
            S_DB_PRESS: begin
                if (!btn_s_q) begin
                    state_d = S_IDLE;
                end else if (dcnt_q == D_LAST) begin
                    state_d     = S_PRESSED;
                    level_d     = 1'b1;
                    press_d     = 1'b1;
                    toggle_d    = ~toggle_q;
                    count_d     = count_q + 8'd1;
                    lcnt_d      = '0;
                    long_done_d = 1'b0;
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                end
            end
            S_PRESSED: begin
                if (!btn_s_q) begin
                    state_d = S_DB_RELEASE;
                    dcnt_d  = '0;
                end else if (!long_done_q && lcnt_q == L_LAST) begin
                    long_d      = 1'b1;
                    long_done_d = 1'b1;
                end else if (!long_done_q) begin
                    lcnt_d = lcnt_q + 1'b1;
                end
            end
            default: begin // S_DB_RELEASE: lcnt frozen so a bounce only delays long_pulse
                if (btn_s_q) begin
                    state_d = S_PRESSED;
                end else if (dcnt_q == D_LAST) begin
                    state_d = S_IDLE;
                    level_d = 1'b0;
                    rel_d   = 1'b1;
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= 1'b0;
            btn_s_q     <= 1'b0;
            state_q     <= S_IDLE;
            dcnt_q      <= '0;
            lcnt_q      <= '0;
            long_done_q <= 1'b0;
            level_q     <= 1'b0;
            press_q     <= 1'b0;
            rel_q       <= 1'b0;
            long_q      <= 1'b0;
            toggle_q    <= 1'b0;
            count_q     <= 8'd0;
        end else begin
            sync1_q     <= bus.btn_in;
            btn_s_q     <= sync1_q;
            state_q     <= state_d;
            dcnt_q      <= dcnt_d;
            lcnt_q      <= lcnt_d;
            long_done_q <= long_done_d;
            level_q     <= level_d;
            press_q     <= press_d;
            rel_q       <= rel_d;
            long_q      <= long_d;
            toggle_q    <= toggle_d;
            count_q     <= count_d;
        end
    end

    assign bus.btn_level     = level_q;
    assign bus.press_pulse   = press_q;
    assign bus.release_pulse = rel_q;
    assign bus.long_pulse    = long_q;
    assign bus.toggle        = toggle_q;
    assign bus.press_count   = count_q;
endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer: bus_a drives a D=4/L=20 instance,
// bus_w a D=2 instance used for the counter wrap.
module tb_button_debouncer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    button_debouncer_if bus_a ();
    button_debouncer_if bus_w ();

    button_debouncer #(.DEBOUNCE_CYCLES(4), .LONG_CYCLES(20)) u_dut (
        .clk(clk), .rst_n(rst_n), .bus(bus_a)
    );
    button_debouncer #(.DEBOUNCE_CYCLES(2), .LONG_CYCLES(20)) u_dut_w (
        .clk(clk), .rst_n(rst_n), .bus(bus_w)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Tallies for bus_a, indexed by edge number since the scenario start.
    int edge_n, n_press, n_rel, n_long, e_press, e_rel, e_long, e_level, n_level;
    int max_cnt, n_press_w;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic clr_tally();
        edge_n = 0; n_press = 0; n_rel = 0; n_long = 0;
        e_press = -1; e_rel = -1; e_long = -1; e_level = -1; n_level = 0;
        max_cnt = 0; n_press_w = 0;
    endtask

    // Drive inputs on the falling edge, observe 1 time unit after the rising edge.
    task automatic step(input logic a, input logic w);
        @(negedge clk);
        rst_n = 1'b1;
        bus_a.btn_in = a;
        bus_w.btn_in = w;
        @(posedge clk);
        #1;
        if (bus_a.press_pulse)   begin n_press++; e_press = edge_n; end
        if (bus_a.release_pulse) begin n_rel++;   e_rel   = edge_n; end
        if (bus_a.long_pulse)    begin n_long++;  e_long  = edge_n; end
        if (bus_a.btn_level) begin
            n_level++;
            if (e_level < 0) e_level = edge_n;
        end
        if (int'(bus_a.press_count) > max_cnt) max_cnt = int'(bus_a.press_count);
        if (bus_w.press_pulse) n_press_w++;
        edge_n++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus_a.btn_in = 1'b0;
        bus_w.btn_in = 1'b0;
        repeat (2) @(posedge clk);
        clr_tally();
    endtask

    initial begin
        bus_a.btn_in = 1'b0;
        bus_w.btn_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_level", int'(bus_a.btn_level), 0);
        check("rst_pulses", int'({bus_a.press_pulse, bus_a.release_pulse, bus_a.long_pulse}), 0);
        check("rst_count", int'(bus_a.press_count), 0);
        check("rst_toggle", int'(bus_a.toggle), 0);

        // Clean press held 41 edges
        clr_tally();
        for (int i = 0; i < 41; i++) step(1'b1, 1'b0);
        $display("clean press: press@%0d long@%0d count=%0d", e_press, e_long, bus_a.press_count);
        check("clean_press_n", n_press, 1);
        check("clean_press_edge", e_press, 6);
        check("clean_level_edge", e_level, 6);
        check("clean_toggle", int'(bus_a.toggle), 1);
        check("clean_count", int'(bus_a.press_count), 1);
        check("clean_long_n", n_long, 1);
        check("clean_long_edge", e_long, 26);
        check("clean_rel_n", n_rel, 0);

        // Bounce reject
        do_reset();
        for (int r = 0; r < 5; r++) begin
            for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
            for (int i = 0; i < 2; i++) step(1'b0, 1'b0);
        end
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0);
        $display("bounce: press=%0d rel=%0d long=%0d level_cycles=%0d", n_press, n_rel, n_long, n_level);
        check("bounce_strobes", n_press + n_rel + n_long, 0);
        check("bounce_level", n_level, 0);
        check("bounce_count", max_cnt, 0);

        // Release with a 2-cycle dropout
        do_reset();
        for (int i = 0; i < 50; i++) step((i < 15 || (i >= 17 && i < 30)) ? 1'b1 : 1'b0, 1'b0);
        $display("release bounce: press@%0d long@%0d rel@%0d", e_press, e_long, e_rel);
        check("rb_press_n", n_press, 1);
        check("rb_long_n", n_long, 1);
        check("rb_long_edge", e_long, 29);
        check("rb_rel_n", n_rel, 1);
        check("rb_rel_edge", e_rel, 36);
        check("rb_level_end", int'(bus_a.btn_level), 0);

        // Short press: 10 cycles high
        do_reset();
        for (int i = 0; i < 40; i++) step((i < 10) ? 1'b1 : 1'b0, 1'b0);
        $display("short press: press@%0d rel@%0d long=%0d", e_press, e_rel, n_long);
        check("short_press_n", n_press, 1);
        check("short_press_edge", e_press, 6);
        check("short_rel_n", n_rel, 1);
        check("short_rel_edge", e_rel, 16);
        check("short_long_n", n_long, 0);

        // Reset mid-hold (lcnt = 10 after edge 16)
        do_reset();
        for (int i = 0; i < 17; i++) step(1'b1, 1'b0);
        check("mid_level_before", int'(bus_a.btn_level), 1);
        #2 rst_n = 1'b0;
        #1;
        $display("mid reset: level=%0d count=%0d toggle=%0d", bus_a.btn_level, bus_a.press_count, bus_a.toggle);
        check("mid_rst_level", int'(bus_a.btn_level), 0);
        check("mid_rst_count", int'(bus_a.press_count), 0);
        check("mid_rst_toggle", int'(bus_a.toggle), 0);
        check("mid_rst_pulses", int'({bus_a.press_pulse, bus_a.release_pulse, bus_a.long_pulse}), 0);
        @(posedge clk);
        clr_tally();
        for (int i = 0; i < 13; i++) step(1'b1, 1'b0);
        $display("after reset: press@%0d count=%0d rel=%0d", e_press, bus_a.press_count, n_rel);
        check("post_rst_press_edge", e_press, 6);
        check("post_rst_press_n", n_press, 1);
        check("post_rst_count", int'(bus_a.press_count), 1);
        check("post_rst_rel_n", n_rel, 0);

        // Counter wrap on the D=2 instance
        do_reset();
        for (int p = 0; p < 256; p++) begin
            for (int i = 0; i < 6; i++) step(1'b0, 1'b1);
            for (int i = 0; i < 6; i++) step(1'b0, 1'b0);
        end
        $display("wrap 256: count=%0d toggle=%0d pulses=%0d", bus_w.press_count, bus_w.toggle, n_press_w);
        check("wrap256_count", int'(bus_w.press_count), 0);
        check("wrap256_toggle", int'(bus_w.toggle), 0);
        check("wrap256_pulses", n_press_w, 256);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1);
        $display("wrap 257: count=%0d toggle=%0d", bus_w.press_count, bus_w.toggle);
        check("wrap257_count", int'(bus_w.press_count), 1);
        check("wrap257_toggle", int'(bus_w.toggle), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
